// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: one-hot T-state ring (fetch T1-T3, execute T4-T6) that
// decodes the IR opcode into bus enable/latch strobes, never more than one bus driver per cycle.
module sap_controller #(
   parameter logic [3:0] OP_LDA    = 4'h0,
   parameter logic [3:0] OP_ADD    = 4'h1,
   parameter logic [3:0] OP_SUB    = 4'h2,
   parameter logic [3:0] OP_OUT    = 4'hE,
   parameter logic [3:0] OP_HLT    = 4'hF,
   parameter bit         EARLY_END = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] opcode,
   output logic       pc_en,
   output logic       pc_inc,
   output logic       mar_latch,
   output logic       ram_en,
   output logic       ir_latch,
   output logic       ir_en,
   output logic       a_latch,
   output logic       a_en,
   output logic       b_latch,
   output logic       alu_en,
   output logic       alu_sub,
   output logic       out_latch,
   output logic [5:0] tstate,
   output logic       halted
);

   // state | meaning
   // T1    | PC -> MAR
   // T2    | PC increment
   // T3    | RAM[MAR] -> IR
   // T4    | LDA/ADD/SUB: operand -> MAR; OUT: A -> OUT; HLT: halt (ring parks here)
   // T5    | LDA: RAM -> A; ADD/SUB: RAM -> B
   // T6    | ADD/SUB: ALU -> A
   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   tstate_e state_q, state_d;
   logic    halted_d;
   logic    last_t;
   logic    active;
   logic    is_mem_op;

   assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
   assign tstate    = state_q;
   // reset gates the strobes directly so they drop the instant reset asserts
   assign active    = reset && run && !halted;

   // the T3 early exit for NOPs sees whatever opcode the IR presents during T3
   always_comb begin
      last_t = (state_q == T6);
      if (EARLY_END) begin
         if (opcode == OP_LDA)
            last_t = (state_q == T5);
         else if ((opcode == OP_ADD) || (opcode == OP_SUB))
            last_t = (state_q == T6);
         else if ((opcode == OP_OUT) || (opcode == OP_HLT))
            last_t = (state_q == T4);
         else
            last_t = (state_q == T3);
      end
   end

   always_comb begin
      state_d  = state_q;
      halted_d = halted;
      if (run && !halted) begin
         if ((state_q == T4) && (opcode == OP_HLT))
            halted_d = 1'b1;
         else if (last_t)
            state_d = T1;
         else begin
            case (state_q)
               T1:      state_d = T2;
               T2:      state_d = T3;
               T3:      state_d = T4;
               T4:      state_d = T5;
               T5:      state_d = T6;
               default: state_d = T1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= T1;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         halted  <= halted_d;
      end
   end

   always_comb begin
      pc_en     = 1'b0;
      pc_inc    = 1'b0;
      mar_latch = 1'b0;
      ram_en    = 1'b0;
      ir_latch  = 1'b0;
      ir_en     = 1'b0;
      a_latch   = 1'b0;
      a_en      = 1'b0;
      b_latch   = 1'b0;
      alu_en    = 1'b0;
      alu_sub   = 1'b0;
      out_latch = 1'b0;
      if (active) begin
         case (state_q)
            T1: begin
               pc_en     = 1'b1;
               mar_latch = 1'b1;
            end
            T2: pc_inc = 1'b1;
            T3: begin
               ram_en   = 1'b1;
               ir_latch = 1'b1;
            end
            T4: begin
               if (is_mem_op) begin
                  ir_en     = 1'b1;
                  mar_latch = 1'b1;
               end else if (opcode == OP_OUT) begin
                  a_en      = 1'b1;
                  out_latch = 1'b1;
               end
            end
            T5: begin
               if (opcode == OP_LDA) begin
                  ram_en  = 1'b1;
                  a_latch = 1'b1;
               end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  ram_en  = 1'b1;
                  b_latch = 1'b1;
               end
            end
            T6: begin
               if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                  alu_en  = 1'b1;
                  alu_sub = (opcode == OP_SUB);
                  a_latch = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: table of per-cycle control words for full instructions,
// plus hand sequences for halt, early end, run freeze and asynchronous reset.
module tb_sap_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b1;
   logic [3:0] opcode = 4'h0;

   logic pc_en0, pc_inc0, mar_latch0, ram_en0, ir_latch0, ir_en0;
   logic a_latch0, a_en0, b_latch0, alu_en0, alu_sub0, out_latch0, halted0;
   logic [5:0] tstate0;
   logic pc_en1, pc_inc1, mar_latch1, ram_en1, ir_latch1, ir_en1;
   logic a_latch1, a_en1, b_latch1, alu_en1, alu_sub1, out_latch1, halted1;
   logic [5:0] tstate1;
   logic [11:0] w0, w1;

   int n_vec = 0;
   int n_err = 0;

   // word bits: pc_en pc_inc mar_latch ram_en ir_latch ir_en a_latch a_en b_latch alu_en alu_sub out_latch
   localparam logic [11:0] W_0     = 12'b0000_0000_0000;
   localparam logic [11:0] W_T1    = 12'b1010_0000_0000;
   localparam logic [11:0] W_T2    = 12'b0100_0000_0000;
   localparam logic [11:0] W_T3    = 12'b0001_1000_0000;
   localparam logic [11:0] W_IRMAR = 12'b0010_0100_0000;
   localparam logic [11:0] W_LDA5  = 12'b0001_0010_0000;
   localparam logic [11:0] W_B5    = 12'b0001_0000_1000;
   localparam logic [11:0] W_ADD6  = 12'b0000_0010_0100;
   localparam logic [11:0] W_SUB6  = 12'b0000_0010_0110;
   localparam logic [11:0] W_OUT4  = 12'b0000_0001_0001;

   always #5 clk = ~clk;

   sap_controller #(.EARLY_END(1'b0)) u0 (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .pc_en(pc_en0), .pc_inc(pc_inc0), .mar_latch(mar_latch0), .ram_en(ram_en0),
      .ir_latch(ir_latch0), .ir_en(ir_en0), .a_latch(a_latch0), .a_en(a_en0),
      .b_latch(b_latch0), .alu_en(alu_en0), .alu_sub(alu_sub0), .out_latch(out_latch0),
      .tstate(tstate0), .halted(halted0)
   );

   sap_controller #(.EARLY_END(1'b1)) u1 (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .pc_en(pc_en1), .pc_inc(pc_inc1), .mar_latch(mar_latch1), .ram_en(ram_en1),
      .ir_latch(ir_latch1), .ir_en(ir_en1), .a_latch(a_latch1), .a_en(a_en1),
      .b_latch(b_latch1), .alu_en(alu_en1), .alu_sub(alu_sub1), .out_latch(out_latch1),
      .tstate(tstate1), .halted(halted1)
   );

   assign w0 = {pc_en0, pc_inc0, mar_latch0, ram_en0, ir_latch0, ir_en0,
                a_latch0, a_en0, b_latch0, alu_en0, alu_sub0, out_latch0};
   assign w1 = {pc_en1, pc_inc1, mar_latch1, ram_en1, ir_latch1, ir_en1,
                a_latch1, a_en1, b_latch1, alu_en1, alu_sub1, out_latch1};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic bus_ok(input logic [11:0] w);
      int n_en;
      int n_lat;
      n_en  = int'(w[11]) + int'(w[8]) + int'(w[6]) + int'(w[4]) + int'(w[2]);
      n_lat = int'(w[9]) + int'(w[7]) + int'(w[5]) + int'(w[3]) + int'(w[0]);
      return (n_en <= 1) && ((n_lat == 0) || (n_en == 1));
   endfunction

   always @(negedge clk) begin
      #2;
      chk("bus_inv_u0", 32'(bus_ok(w0)), 32'd1);
      chk("bus_inv_u1", 32'(bus_ok(w1)), 32'd1);
   end

   typedef struct {
      logic        rst;
      logic        run;
      logic [3:0]  op;
      logic [11:0] word;
      logic [5:0]  ts;
      logic        hlt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rn, input logic [3:0] op,
                      input logic [11:0] w, input logic [5:0] ts, input logic h);
      vec_t v;
      v.rst = r; v.run = rn; v.op = op; v.word = w; v.ts = ts; v.hlt = h;
      tbl.push_back(v);
   endtask

   task automatic add_instr(input logic [3:0] op, input logic [11:0] w4,
                            input logic [11:0] w5, input logic [11:0] w6);
      add(1, 1, op, W_T1, 6'b000001, 0);
      add(1, 1, op, W_T2, 6'b000010, 0);
      add(1, 1, op, W_T3, 6'b000100, 0);
      add(1, 1, op, w4,   6'b001000, 0);
      add(1, 1, op, w5,   6'b010000, 0);
      add(1, 1, op, w6,   6'b100000, 0);
   endtask

   task automatic early_seq(input string nm, input logic [3:0] op, input int len);
      opcode = op;
      for (int k = 0; k <= len; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         chk($sformatf("%s_t%0d", nm, k), 32'(tstate1),
             (k == len) ? 32'd1 : (32'd1 << k));
      end
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 3; i++) add(0, 1, 4'h0, W_0, 6'b000001, 0);
      add_instr(4'h0, W_IRMAR, W_LDA5, W_0);
      add_instr(4'h2, W_IRMAR, W_B5,   W_SUB6);
      add_instr(4'h1, W_IRMAR, W_B5,   W_ADD6);
      add_instr(4'hE, W_OUT4,  W_0,    W_0);
      add_instr(4'h7, W_0,     W_0,    W_0);
      add(1, 1, 4'hF, W_T1, 6'b000001, 0);
      add(1, 1, 4'hF, W_T2, 6'b000010, 0);
      add(1, 1, 4'hF, W_T3, 6'b000100, 0);
      add(1, 1, 4'hF, W_0,  6'b001000, 0);
      add(1, 1, 4'hF, W_0,  6'b001000, 1);

      foreach (tbl[i]) begin
         @(negedge clk);
         reset = tbl[i].rst;
         run = tbl[i].run;
         opcode = tbl[i].op;
         #1;
         chk($sformatf("vec%0d_word", i), 32'(w0), 32'(tbl[i].word));
         chk($sformatf("vec%0d_tstate", i), 32'(tstate0), 32'(tbl[i].ts));
         chk($sformatf("vec%0d_halted", i), 32'(halted0), 32'(tbl[i].hlt));
      end

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         chk("halt_word", 32'(w0), 32'(W_0));
         chk("halt_tstate", 32'(tstate0), 32'd8);
         chk("halt_flag", 32'(halted0), 32'd1);
      end

      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("halt_rst_flag", 32'(halted0), 32'd0);
      chk("halt_rst_tstate", 32'(tstate0), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("resume_word", 32'(w0), 32'(W_T1));
      chk("resume_tstate_u1", 32'(tstate1), 32'd1);

      early_seq("early_out", 4'hE, 4);
      early_seq("early_nop", 4'h7, 3);
      early_seq("early_lda", 4'h0, 5);
      early_seq("early_add", 4'h1, 6);
      early_seq("early_sub", 4'h2, 6);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      opcode = 4'h0;
      #1;
      chk("frz_t1", 32'(tstate0), 32'd1);
      @(negedge clk);
      #1;
      chk("frz_t2_word", 32'(w0), 32'(W_T2));
      run = 1'b0;
      #1;
      chk("frz_pcinc_now", 32'(pc_inc0), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("frz_pcinc", 32'(pc_inc0), 32'd0);
         chk("frz_tstate", 32'(tstate0), 32'd2);
      end
      @(negedge clk);
      run = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         cnt += int'(pc_inc0);
         @(negedge clk);
      end
      chk("frz_pcinc_once", 32'(cnt), 32'd1);
      #1;
      chk("t5_word", 32'(w0), 32'(W_LDA5));
      chk("t5_tstate", 32'(tstate0), 32'd16);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_word", 32'(w0), 32'(W_0));
      chk("async_rst_tstate", 32'(tstate0), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
